// File: rtl/ysyx_23060203_rd_sched.sv
// Two-master AXI4 read scheduler: m1 (LSU) has priority, m0 (IFU) is forced in after STARVE_MAX lost rounds.
// One transaction outstanding at a time; the grant is held from the AR handshake until the RLAST beat.
module ysyx_23060203_rd_sched #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clock,
  input  logic          reset,
  // master 0 (instruction fetch)
  input  logic          m0_arvalid,
  output logic          m0_arready,
  input  logic [AW-1:0] m0_araddr,
  input  logic [7:0]    m0_arlen,
  input  logic [2:0]    m0_arsize,
  output logic          m0_rvalid,
  input  logic          m0_rready,
  output logic [DW-1:0] m0_rdata,
  output logic [1:0]    m0_rresp,
  output logic          m0_rlast,
  // master 1 (load)
  input  logic          m1_arvalid,
  output logic          m1_arready,
  input  logic [AW-1:0] m1_araddr,
  input  logic [7:0]    m1_arlen,
  input  logic [2:0]    m1_arsize,
  output logic          m1_rvalid,
  input  logic          m1_rready,
  output logic [DW-1:0] m1_rdata,
  output logic [1:0]    m1_rresp,
  output logic          m1_rlast,
  // shared slave port
  output logic          s_arvalid,
  input  logic          s_arready,
  output logic [AW-1:0] s_araddr,
  output logic [7:0]    s_arlen,
  output logic [2:0]    s_arsize,
  input  logic          s_rvalid,
  output logic          s_rready,
  input  logic [DW-1:0] s_rdata,
  input  logic [1:0]    s_rresp,
  input  logic          s_rlast
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state, state_nxt;
  logic       gnt, gnt_nxt;
  logic [3:0] starve, starve_nxt;
  logic       win;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      starve <= 4'd0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    starve_nxt = starve;
    win        = 1'b0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;

    unique case (state)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          // m1 wins unless m0 has already lost STARVE_MAX rounds in a row
          win       = m1_arvalid && !(m0_arvalid && (starve == STARVE_LIM));
          gnt_nxt   = win;
          state_nxt = ADDR;
          if (!win) begin
            starve_nxt = 4'd0;
          end else if (m0_arvalid && (starve < STARVE_LIM)) begin
            starve_nxt = starve + 4'd1;
          end
        end
      end

      ADDR: begin
        // valid comes from the state register so no m*_arvalid -> s_arvalid path exists
        s_arvalid = 1'b1;
        if (gnt) begin
          s_araddr   = m1_araddr;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          m0_arready = s_arready;
        end
        if (s_arready) state_nxt = DATA;
      end

      DATA: begin
        if (gnt) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rlast  = s_rlast;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rlast  = s_rlast;
          s_rready  = m0_rready;
        end
        if (s_rvalid && s_rready && s_rlast) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_rd_sched.sv
// Directed bench for the two-master read scheduler: reset, single fetch, starvation, bursts,
// backpressure and asynchronous reset mid-beat, all against hand-computed expectations.
module tb_ysyx_23060203_rd_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_rresp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ysyx_23060203_rd_sched #(.STARVE_MAX(4), .AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // every handshake-related output packed together; all zero when idle or in reset
  function automatic logic [63:0] ctl_vec();
    return {56'd0, s_arvalid, s_rready, m0_arready, m1_arready,
            m0_rvalid, m1_rvalid, m0_rlast, m1_rlast};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // advance until the scheduler presents an AR on the slave side
  task automatic wait_ar(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (s_arvalid) ok = 1'b1;
      else cyc();
    end
    if (!ok) chk({tag, "_ar_timeout"}, 64'd0, 64'd1);
  endtask

  logic [31:0] exp_addr [6];
  int          nb;

  initial begin
    reset = 1'b0;
    m0_arvalid = 0; m0_araddr = 0; m0_arlen = 0; m0_arsize = 3'd2; m0_rready = 1;
    m1_arvalid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 3'd2; m1_rready = 1;
    s_arready = 1; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0;

    // reset state
    #3;
    chk("rst_ctl", ctl_vec(), 64'd0);
    chk("rst_data", {m0_rdata, m1_rdata}, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk("idle_ctl", ctl_vec(), 64'd0);
      cyc();
    end

    // m0 alone, single beat
    m0_arvalid = 1; m0_araddr = 32'h3000_0000; m0_arlen = 0;
    #1 chk("t2_arb_cycle", s_arvalid, 0);
    cyc();
    #1 chk("t2_araddr", s_araddr, 64'h3000_0000);
    chk("t2_arready", {m0_arready, m1_arready, s_arvalid}, 64'b101);
    cyc();
    m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 0; s_rlast = 1;
    #1 chk("t2_m0_beat", {m0_rvalid, m0_rlast, m0_rdata}, {2'b11, 32'hDEAD_BEEF});
    chk("t2_m1_quiet", {m1_rvalid, m1_rdata}, 64'd0);
    chk("t2_rready", s_rready, 1);
    cyc();
    s_rvalid = 0; s_rlast = 0; s_rdata = 0;
    #1 chk("t2_back_idle", {m0_rvalid, m0_rdata}, 64'd0);

    // both request continuously: four m1 grants, then m0 forced, then m1 again
    cyc();
    m0_arvalid = 1; m0_araddr = 32'h1000_0000;
    m1_arvalid = 1; m1_araddr = 32'h2000_0000; m1_arlen = 0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'h55;
    exp_addr = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000,
                 32'h2000_0000, 32'h1000_0000, 32'h2000_0000};
    for (int g = 0; g < 6; g++) begin
      wait_ar("t3");
      chk($sformatf("t3_grant%0d", g), s_araddr, 64'(exp_addr[g]));
      if (g == 4) chk("t3_starve_clr", dut.starve, 64'd0);
      cyc();
    end
    m0_arvalid = 0; m1_arvalid = 0;
    cyc();
    s_rvalid = 0; s_rlast = 0;
    #1 chk("t3_idle", ctl_vec(), 64'd0);

    // m1 4-beat burst, m0 arrives during beat 2 and must wait for rlast
    cyc();
    m1_arvalid = 1; m1_araddr = 32'h2000_0040; m1_arlen = 8'd3;
    wait_ar("t4");
    chk("t4_arfields", {s_araddr, s_arlen}, {32'h2000_0040, 8'd3});
    cyc();
    m1_arvalid = 0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1; s_rdata = 32'hA0 + b; s_rlast = (b == 3);
      if (b == 1) begin
        m0_arvalid = 1; m0_araddr = 32'h3000_0100; m0_arlen = 0;
      end
      #1 chk($sformatf("t4_beat%0d", b), {m1_rvalid, m1_rlast, m1_rdata},
             {1'b1, (b == 3), 32'hA0 + b});
      chk($sformatf("t4_m0_wait%0d", b), {m0_arready, m0_rvalid}, 64'd0);
      cyc();
    end
    s_rvalid = 0; s_rlast = 0;
    #1 chk("t4_post_last", {s_arvalid, m0_arready}, 64'd0);
    cyc();
    #1 chk("t4_m0_ar", {s_arvalid, m0_arready, s_araddr}, {2'b11, 32'h3000_0100});
    cyc();
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'h77;
    cyc();
    s_rvalid = 0; s_rlast = 0;

    // AR backpressure then toggling rready on a 2-beat m1 burst with an error beat
    s_arready = 0;
    m1_arvalid = 1; m1_araddr = 32'h2000_0080; m1_arlen = 8'd1;
    wait_ar("t5");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d", i), {s_arvalid, m1_arready, s_araddr, s_arlen},
          {2'b10, 32'h2000_0080, 8'd1});
      cyc();
      #1;
    end
    s_arready = 1;
    #1 chk("t5_arready", m1_arready, 1);
    cyc();
    m1_arvalid = 0;
    nb = 0;
    for (int i = 0; i < 20 && nb < 2; i++) begin
      s_rvalid = 1;
      s_rdata  = (nb == 0) ? 32'h11 : 32'h22;
      s_rresp  = (nb == 0) ? 2'b00 : 2'b10;
      s_rlast  = (nb == 1);
      m1_rready = i[0];
      #1 chk($sformatf("t5_beat_c%0d", i), {m1_rvalid, m1_rlast, m1_rresp, m1_rdata},
             {1'b1, (nb == 1), (nb == 0) ? 2'b00 : 2'b10, (nb == 0) ? 32'h11 : 32'h22});
      chk($sformatf("t5_rready_c%0d", i), s_rready, 64'(i[0]));
      if (m1_rready) nb++;
      cyc();
    end
    s_rvalid = 0; s_rlast = 0; s_rresp = 0; m1_rready = 1;
    #1 chk("t5_no_dup", {m1_rvalid, s_rready}, 64'd0);

    // asynchronous reset while a beat is on the wire
    cyc();
    m0_arvalid = 1; m0_araddr = 32'h3000_0200; m0_arlen = 0;
    wait_ar("t6");
    cyc();
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'hCAFE; m0_rready = 0;
    #1 chk("t6_beat_vis", m0_rvalid, 1);
    #1 reset = 0;
    #1 chk("t6_rst_ctl", ctl_vec(), 64'd0);
    chk("t6_rst_data", {m0_rdata, m1_rdata}, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1; s_rvalid = 0; s_rlast = 0; m0_rready = 1;
    chk("t6_starve", dut.starve, 64'd0);
    m0_arvalid = 1; m0_araddr = 32'h3000_0300;
    wait_ar("t6b");
    chk("t6_regrant", {m0_arready, s_araddr}, {1'b1, 32'h3000_0300});
    cyc();
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 32'h99;
    #1 chk("t6_beat", {m0_rvalid, m0_rdata}, {1'b1, 32'h99});
    cyc();
    s_rvalid = 0; s_rlast = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
